edge_delay_trigger: RTL

- Multi-channel delayed-trigger generator for stimulus and bench sequencing.
- Each channel detects a rising edge on its `enable` input, waits a programmable number of `clk` rising edges, then asserts `trigger`.
- Generalises the single fixed 5-cycle edge-wait: parametrised channel count and counter width, runtime per-channel delay, level/pulse output modes, selectable retrigger policy, and sticky overrun reporting.

---
 rtl/edge_delay_trigger.sv | 134 +++++++++++++
 1 files changed

// File: rtl/edge_delay_trigger.sv
// edge_delay_trigger: multi-channel delayed-trigger generator.
// Each channel watches its enable input for a rising edge. It then counts a
// per-channel programmable number of clk edges and asserts trigger, either as
// a held level or as a single-cycle pulse.
//
// Parameters
//   CHANNELS  : number of independent channels
//   CNT_W     : delay counter width (max delay 2**CNT_W-1 cycles)
//   RETRIGGER : 1 = an edge during a countdown restarts it,
//               0 = an edge during a countdown is ignored
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : synchronous reset, active-high
//   enable   : per-channel start request (rising edge starts a count)
//   delay    : per-channel delay D, channel i at [i*CNT_W +: CNT_W]
//   mode     : per-channel output mode, 0 = level, 1 = one-cycle pulse
//   ovr_clr  : per-channel clear of the sticky overrun flag
//   trigger  : per-channel delayed trigger (registered)
//   busy     : per-channel "counting" flag (registered)
//   overrun  : per-channel sticky flag, an edge arrived while counting
module edge_delay_trigger #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 8,
    parameter bit          RETRIGGER = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS*CNT_W-1:0] delay,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       ovr_clr,
    output logic [CHANNELS-1:0]       trigger,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch

        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q,   cnt_d;
        logic             mode_q,  mode_d;
        logic             trig_q,  trig_d;
        logic             ovr_q,   ovr_d;
        logic             busy_q;
        logic             hist_q;

        logic             rise;
        logic             start;
        logic [CNT_W-1:0] d_in;

        assign d_in = delay[i*CNT_W +: CNT_W];
        assign rise = enable[i] & ~hist_q;

        // An edge starts a new count unless we are counting and restarts are disabled.
        assign start = rise & ((state_q != S_COUNT) | RETRIGGER);

        // Next-state logic for one channel.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            mode_d  = mode_q;
            trig_d  = trig_q;
            ovr_d   = ovr_q;

            // IDLE only carries trigger high during the one pulse cycle; drop it.
            if (state_q == S_IDLE) begin
                trig_d = 1'b0;
            end

            // Set wins over clear.
            if (ovr_clr[i]) begin
                ovr_d = 1'b0;
            end
            if (rise && (state_q == S_COUNT)) begin
                ovr_d = 1'b1;
            end

            if (start) begin
                mode_d = mode[i];
                if (d_in == '0) begin
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = mode[i] ? S_IDLE : S_DONE;
                end else begin
                    trig_d  = 1'b0;
                    cnt_d   = d_in;
                    state_d = S_COUNT;
                end
            end else if (state_q == S_COUNT) begin
                if (cnt_q == CNT_W'(1)) begin
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = mode_q ? S_IDLE : S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end

        // Channel registers; the edge history tracks enable even in reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                mode_q  <= 1'b0;
                trig_q  <= 1'b0;
                ovr_q   <= 1'b0;
                busy_q  <= 1'b0;
                hist_q  <= enable[i];
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                mode_q  <= mode_d;
                trig_q  <= trig_d;
                ovr_q   <= ovr_d;
                busy_q  <= (state_d == S_COUNT);
                hist_q  <= enable[i];
            end
        end

        assign trigger[i] = trig_q;
        assign busy[i]    = busy_q;
        assign overrun[i] = ovr_q;

    end : g_ch

endmodule : edge_delay_trigger
